// File: rtl/rv_pkg.sv
// Shared definitions for the rv core slice: bus width, key controller register
// map and small helpers.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] KEY_STATE_IDX   = 2'd0;
    localparam logic [1:0] KEY_PRESS_IDX   = 2'd1;
    localparam logic [1:0] KEY_RELEASE_IDX = 2'd2;
    localparam logic [1:0] KEY_COUNT_IDX   = 2'd3;

    localparam int KEY_COUNT_W = 16;

    function automatic logic [KEY_COUNT_W-1:0] key_popcount(input logic [15:0] bits);
        logic [KEY_COUNT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            sum = sum + {{(KEY_COUNT_W-1){1'b0}}, bits[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/rv_key_debounce.sv
// One key: polarity correction, 2-FF synchroniser and persistence counter that
// flips the stable level once a new level has held for DEBOUNCE_CYCLES samples.
module rv_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic key_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             key_s;
    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             flip_s;

    assign key_s = key_i ^ ACTIVE_LOW;

    // Counter restarts whenever the synchronised level agrees with the stable one.
    always_comb begin
        cnt_nxt_s = '0;
        flip_s    = 1'b0;
        if (sync2_r == level_r) begin
            cnt_nxt_s = '0;
        end else if (cnt_r == CNT_MAX) begin
            flip_s    = 1'b1;
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Synchroniser, persistence counter and stable level.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            cnt_r   <= '0;
            level_r <= 1'b0;
        end else begin
            sync1_r <= key_s;
            sync2_r <= sync1_r;
            cnt_r   <= cnt_nxt_s;
            level_r <= level_r ^ flip_s;
        end
    end

    assign level_o = level_r;
    assign rise_o  = flip_s & ~level_r;
    assign fall_o  = flip_s & level_r;

endmodule

// File: rtl/rv_key_ctrl.sv
// Memory-mapped push-button peripheral: debounced STATE, sticky W1C PRESS and
// RELEASE flags, a press COUNT and a fixed one-cycle rvalid response.
module rv_key_ctrl
    import rv_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit KEYS_ACTIVE_LOW = 1'b1
) (
    input  logic                clk_i,
    input  logic                arstn_i,
    input  logic [NUM_KEYS-1:0] keys_i,
    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [XLEN/8-1:0]   data_be_i,
    input  logic [XLEN-1:0]     data_addr_i,
    input  logic [XLEN-1:0]     data_wdata_i,
    output logic                data_rvalid_o,
    output logic [XLEN-1:0]     data_rdata_o
);

    logic [NUM_KEYS-1:0]    level_s;
    logic [NUM_KEYS-1:0]    rise_s;
    logic [NUM_KEYS-1:0]    fall_s;
    logic [NUM_KEYS-1:0]    w1c_s;
    logic [NUM_KEYS-1:0]    press_r;
    logic [NUM_KEYS-1:0]    release_r;
    logic [NUM_KEYS-1:0]    press_nxt_s;
    logic [NUM_KEYS-1:0]    release_nxt_s;
    logic [KEY_COUNT_W-1:0] count_r;
    logic [KEY_COUNT_W-1:0] count_nxt_s;
    logic [KEY_COUNT_W-1:0] rise_cnt_s;
    logic [1:0]             idx_s;
    logic                   wr_s;
    logic                   press_wr_s;
    logic                   release_wr_s;
    logic                   count_clr_s;
    logic [XLEN-1:0]        rd_mux_s;
    logic [XLEN-1:0]        rdata_r;
    logic                   rvalid_r;
    logic                   unused_s;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        rv_key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (KEYS_ACTIVE_LOW)
        ) u_debounce (
            .clk_i   (clk_i),
            .arstn_i (arstn_i),
            .key_i   (keys_i[g]),
            .level_o (level_s[g]),
            .rise_o  (rise_s[g]),
            .fall_o  (fall_s[g])
        );
    end

    assign idx_s        = data_addr_i[3:2];
    assign wr_s         = data_req_i & data_we_i;
    assign press_wr_s   = wr_s & (idx_s == KEY_PRESS_IDX);
    assign release_wr_s = wr_s & (idx_s == KEY_RELEASE_IDX);
    assign count_clr_s  = wr_s & (idx_s == KEY_COUNT_IDX) & (|data_be_i);
    assign rise_cnt_s   = key_popcount(16'(rise_s));
    assign unused_s     = ^{data_addr_i[XLEN-1:4], data_addr_i[1:0], data_wdata_i[XLEN-1:NUM_KEYS]};

    // Event registers: a same-cycle event beats a W1C, and a COUNT clear keeps this cycle's presses.
    always_comb begin
        w1c_s = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            w1c_s[i] = data_wdata_i[i] & data_be_i[i / 8];
        end
        press_nxt_s   = (press_r & ~({NUM_KEYS{press_wr_s}} & w1c_s)) | rise_s;
        release_nxt_s = (release_r & ~({NUM_KEYS{release_wr_s}} & w1c_s)) | fall_s;
        count_nxt_s   = count_clr_s ? rise_cnt_s : (count_r + rise_cnt_s);
    end

    // Read mux over the pre-update register state.
    always_comb begin
        rd_mux_s = '0;
        case (idx_s)
            KEY_STATE_IDX:   rd_mux_s[NUM_KEYS-1:0]    = level_s;
            KEY_PRESS_IDX:   rd_mux_s[NUM_KEYS-1:0]    = press_r;
            KEY_RELEASE_IDX: rd_mux_s[NUM_KEYS-1:0]    = release_r;
            KEY_COUNT_IDX:   rd_mux_s[KEY_COUNT_W-1:0] = count_r;
            default:         rd_mux_s                  = '0;
        endcase
    end

    // Event/count state and the one-cycle response pipeline.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            press_r   <= '0;
            release_r <= '0;
            count_r   <= '0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
        end else begin
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
            count_r   <= count_nxt_s;
            rvalid_r  <= data_req_i;
            rdata_r   <= (data_req_i && !data_we_i) ? rd_mux_s : '0;
        end
    end

    assign data_rvalid_o = rvalid_r;
    assign data_rdata_o  = rdata_r;

endmodule
